// File: rtl/video_timing_pkg.sv
// Shared raster timing defaults, axis-length helper and 2-bit region encoding.
// Used by video_timing, textbuffer and sprite; pure declarations.
package video_timing_pkg;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    RG_ACTIVE = 2'd0,
    RG_FRONT  = 2'd1,
    RG_SYNC   = 2'd2,
    RG_BACK   = 2'd3
  } region_e;

  function automatic int axis_total(input int disp, input int front,
                                    input int sync, input int back);
    return disp + front + sync + back;
  endfunction

  localparam int DEF_H_DISPLAY   = 640;
  localparam int DEF_H_FRONT     = 16;
  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_BACK      = 48;
  localparam int DEF_V_DISPLAY   = 480;
  localparam int DEF_V_FRONT     = 10;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_BACK      = 33;
  localparam int DEF_SCALE_SHIFT = 2;

  localparam int DEF_H_TOTAL = axis_total(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/sync_axis.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK region FSM.
// State and count update together on i_adv; wrap/sync are decoded combinationally, no backpressure.
module sync_axis
  import video_timing_pkg::*;
#(
  parameter int DISPLAY = DEF_H_DISPLAY,
  parameter int FRONT   = DEF_H_FRONT,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BACK    = DEF_H_BACK
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    i_adv,
  output cnt_t    o_cnt,
  output region_e o_state,
  output logic    o_wrap,
  output logic    o_sync
);

  localparam int   TOTAL    = axis_total(DISPLAY, FRONT, SYNC, BACK);
  localparam cnt_t LAST     = cnt_t'(TOTAL - 1);
  localparam cnt_t FRONT_AT = cnt_t'(DISPLAY);
  localparam cnt_t SYNC_AT  = cnt_t'(DISPLAY + FRONT);
  localparam cnt_t BACK_AT  = cnt_t'(DISPLAY + FRONT + SYNC);

  if (TOTAL > (1 << CNT_W)) begin : g_bad_total
    $error("sync_axis: axis total %0d exceeds counter range", TOTAL);
  end

  cnt_t    r_cnt;
  cnt_t    w_cnt_nxt;
  region_e r_state;
  region_e w_state_nxt;
  logic    w_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_state <= RG_ACTIVE;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
    end
  end

  // Transitions look at the next count so the state always names the region of r_cnt.
  always_comb begin
    w_wrap      = i_adv && (r_cnt == LAST);
    w_cnt_nxt   = r_cnt;
    w_state_nxt = r_state;
    if (i_adv) begin
      w_cnt_nxt = w_wrap ? '0 : r_cnt + 10'd1;
      case (r_state)
        RG_ACTIVE: if (w_cnt_nxt == FRONT_AT) w_state_nxt = RG_FRONT;
        RG_FRONT:  if (w_cnt_nxt == SYNC_AT)  w_state_nxt = RG_SYNC;
        RG_SYNC:   if (w_cnt_nxt == BACK_AT)  w_state_nxt = RG_BACK;
        RG_BACK:   if (w_wrap)                w_state_nxt = RG_ACTIVE;
        default:                              w_state_nxt = RG_ACTIVE;
      endcase
    end
  end

  assign o_cnt   = r_cnt;
  assign o_state = r_state;
  assign o_wrap  = w_wrap;
  assign o_sync  = (r_state == RG_SYNC);

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: syncs, logical pixel position, pixel strobe, vblank pulse, frame count.
// Every output registered one clock after its counter position (zero skew); free-running, no backpressure.
module video_timing
  import video_timing_pkg::*;
#(
  parameter int H_DISPLAY   = DEF_H_DISPLAY,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int V_DISPLAY   = DEF_V_DISPLAY,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int SCALE_SHIFT = DEF_SCALE_SHIFT
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] hpos,
  output logic [6:0] vpos,
  output logic       display_on,
  output logic       pix_en,
  output logic       vblank_start,
  output logic [7:0] frame
);

  localparam cnt_t PIX_MASK  = cnt_t'((1 << SCALE_SHIFT) - 1);
  localparam cnt_t VBLANK_AT = cnt_t'(V_DISPLAY);

  cnt_t    w_hcount;
  cnt_t    w_vcount;
  region_e w_hstate;
  region_e w_vstate;
  logic    w_hwrap;
  logic    w_vwrap;
  logic    w_hsync;
  logic    w_vsync;

  sync_axis #(
    .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_haxis (
    .clk    (clk),
    .reset  (reset),
    .i_adv  (1'b1),
    .o_cnt  (w_hcount),
    .o_state(w_hstate),
    .o_wrap (w_hwrap),
    .o_sync (w_hsync)
  );

  sync_axis #(
    .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_vaxis (
    .clk    (clk),
    .reset  (reset),
    .i_adv  (w_hwrap),
    .o_cnt  (w_vcount),
    .o_state(w_vstate),
    .o_wrap (w_vwrap),
    .o_sync (w_vsync)
  );

  logic       w_display;
  logic       w_pix_phase;
  logic       w_vblank;
  logic [7:0] w_hpos;
  logic [6:0] w_vpos;

  assign w_display   = (w_hstate == RG_ACTIVE) && (w_vstate == RG_ACTIVE);
  assign w_pix_phase = ((w_hcount & PIX_MASK) == '0);
  assign w_vblank    = (w_hcount == '0) && (w_vcount == VBLANK_AT);
  assign w_hpos      = 8'(w_hcount >> SCALE_SHIFT);
  assign w_vpos      = 7'(w_vcount >> SCALE_SHIFT);

  logic       r_hsync;
  logic       r_vsync;
  logic [7:0] r_hpos;
  logic [6:0] r_vpos;
  logic       r_display;
  logic       r_pix_en;
  logic       r_vblank;
  logic [7:0] r_frame_cnt;
  logic [7:0] r_frame;

  // r_frame_cnt tracks the counters' frame; r_frame delays it to line up with the other outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hsync     <= 1'b0;
      r_vsync     <= 1'b0;
      r_hpos      <= '0;
      r_vpos      <= '0;
      r_display   <= 1'b0;
      r_pix_en    <= 1'b0;
      r_vblank    <= 1'b0;
      r_frame_cnt <= '0;
      r_frame     <= '0;
    end else begin
      r_hsync   <= w_hsync;
      r_vsync   <= w_vsync;
      r_hpos    <= w_display ? w_hpos : '0;
      r_vpos    <= w_display ? w_vpos : '0;
      r_display <= w_display;
      r_pix_en  <= w_display && w_pix_phase;
      r_vblank  <= w_vblank;
      r_frame   <= r_frame_cnt;
      if (w_vwrap) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign hsync        = r_hsync;
  assign vsync        = r_vsync;
  assign hpos         = r_hpos;
  assign vpos         = r_vpos;
  assign display_on   = r_display;
  assign pix_en       = r_pix_en;
  assign vblank_start = r_vblank;
  assign frame        = r_frame;

endmodule

// File: tb/tb_video_timing.sv
// Directed bench for video_timing: default 800x525 scan, a short-line full-frame instance,
// and a tiny instance run for 256 frames.
module tb_video_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_def, rst_med, rst_sml;

  logic       d_hs, d_vs, d_de, d_pe, d_vb;
  logic [7:0] d_hp, d_fr;
  logic [6:0] d_vp;
  logic       m_hs, m_vs, m_de, m_pe, m_vb;
  logic [7:0] m_hp, m_fr;
  logic [6:0] m_vp;
  logic       s_hs, s_vs, s_de, s_pe, s_vb;
  logic [7:0] s_hp, s_fr;
  logic [6:0] s_vp;

  video_timing u_def (
    .clk(clk), .reset(rst_def), .hsync(d_hs), .vsync(d_vs), .hpos(d_hp), .vpos(d_vp),
    .display_on(d_de), .pix_en(d_pe), .vblank_start(d_vb), .frame(d_fr)
  );

  // 24-clock lines, default vertical timing: a whole frame is 12600 clocks.
  video_timing #(.H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2)) u_med (
    .clk(clk), .reset(rst_med), .hsync(m_hs), .vsync(m_vs), .hpos(m_hp), .vpos(m_vp),
    .display_on(m_de), .pix_en(m_pe), .vblank_start(m_vb), .frame(m_fr)
  );

  video_timing #(
    .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SCALE_SHIFT(0)
  ) u_sml (
    .clk(clk), .reset(rst_sml), .hsync(s_hs), .vsync(s_vs), .hpos(s_hp), .vpos(s_vp),
    .display_on(s_de), .pix_en(s_pe), .vblank_start(s_vb), .frame(s_fr)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
    end
  endtask

  function automatic logic [31:0] pack(input logic hs, input logic vs, input logic de,
                                       input logic pe, input logic vb, input logic [7:0] hp,
                                       input logic [6:0] vp, input logic [7:0] fr);
    return {4'b0, hs, vs, de, pe, vb, hp, vp, fr};
  endfunction

  // pos = clocks since reset release minus one, i.e. the raster position the outputs describe.
  typedef struct {
    int          pos;
    logic [31:0] want;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  int hs_err, de_err, hp_err, pe_cnt, vs_err, vb_cnt, vb_pos, sync_err, pe_err;
  int vi, line, col;
  logic exp_de;

  initial begin
    //            hs    vs    de    pe    vb    hpos     vpos   frame
    vecs[0]  = '{0,    pack(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   7'd0, 8'd0)};
    vecs[1]  = '{1,    pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   7'd0, 8'd0)};
    vecs[2]  = '{4,    pack(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1,   7'd0, 8'd0)};
    vecs[3]  = '{7,    pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1,   7'd0, 8'd0)};
    vecs[4]  = '{8,    pack(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2,   7'd0, 8'd0)};
    vecs[5]  = '{639,  pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd159, 7'd0, 8'd0)};
    vecs[6]  = '{640,  pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   7'd0, 8'd0)};
    vecs[7]  = '{655,  pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   7'd0, 8'd0)};
    vecs[8]  = '{656,  pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   7'd0, 8'd0)};
    vecs[9]  = '{751,  pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   7'd0, 8'd0)};
    vecs[10] = '{752,  pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   7'd0, 8'd0)};
    vecs[11] = '{799,  pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   7'd0, 8'd0)};
    vecs[12] = '{800,  pack(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   7'd0, 8'd0)};
    vecs[13] = '{3205, pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1,   7'd1, 8'd0)};
    vecs[14] = '{3208, pack(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2,   7'd1, 8'd0)};

    rst_def = 1'b1;
    rst_med = 1'b1;
    rst_sml = 1'b1;
    repeat (3) @(negedge clk);
    check("reset def outputs", pack(d_hs, d_vs, d_de, d_pe, d_vb, d_hp, d_vp, d_fr), 32'd0);
    check("reset sml outputs", pack(s_hs, s_vs, s_de, s_pe, s_vb, s_hp, s_vp, s_fr), 32'd0);

    // Default timing: table vectors plus whole-line scans of line 0.
    rst_def = 1'b0;
    vi = 0; hs_err = 0; de_err = 0; hp_err = 0; pe_cnt = 0;
    for (int p = 0; p <= 3208; p++) begin
      @(negedge clk);
      if (p < 800) begin
        if (d_hs != (p >= 656 && p <= 751)) hs_err++;
        if (d_de != (p < 640)) de_err++;
        if (d_hp != ((p < 640) ? 8'(p >> 2) : 8'd0)) hp_err++;
        if (d_pe) pe_cnt++;
      end
      if (vi < NV && p == vecs[vi].pos) begin
        check($sformatf("def pos %0d", p),
              pack(d_hs, d_vs, d_de, d_pe, d_vb, d_hp, d_vp, d_fr), vecs[vi].want);
        vi++;
      end
    end
    check("def vectors reached", vi, NV);
    check("def line0 hsync window errors", hs_err, 0);
    check("def line0 display window errors", de_err, 0);
    check("def line0 hpos errors", hp_err, 0);
    check("def line0 pix_en pulses", pe_cnt, 160);
    rst_def = 1'b1;

    // Short lines, full frame, then a mid-hsync reset in frame 1 at line 300 column 20.
    rst_med = 1'b0;
    vs_err = 0; vb_cnt = 0; vb_pos = -1;
    for (int p = 0; p <= 19820; p++) begin
      @(negedge clk);
      line = (p / 24) % 525;
      if (p < 12600) begin
        if (m_vs != (line == 490 || line == 491)) vs_err++;
        if (m_vb) begin
          vb_cnt++;
          vb_pos = p;
        end
      end
      if (p == 479 * 24) check("med line479 de/vpos", 32'({m_de, m_vp}), 32'({1'b1, 7'd119}));
      if (p == 480 * 24) check("med line480 de/vpos", 32'({m_de, m_vp}), 32'd0);
      if (p == 12599) check("med frame before wrap", 32'(m_fr), 32'd0);
      if (p == 12600) check("med frame after wrap", 32'(m_fr), 32'd1);
    end
    check("med vsync line window errors", vs_err, 0);
    check("med vblank pulse count", vb_cnt, 1);
    check("med vblank position", vb_pos, 480 * 24);
    check("med hsync before reset", 32'(m_hs), 32'd1);
    #2 rst_med = 1'b1;
    #1 check("med async reset outputs",
             pack(m_hs, m_vs, m_de, m_pe, m_vb, m_hp, m_vp, m_fr), 32'd0);
    repeat (3) @(negedge clk);
    rst_med = 1'b0;
    for (int p = 0; p <= 18; p++) begin
      @(negedge clk);
      if (p == 0)
        check("med restart pos 0", pack(m_hs, m_vs, m_de, m_pe, m_vb, m_hp, m_vp, m_fr),
              pack(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 7'd0, 8'd0));
      if (p == 17) check("med restart hsync col17", 32'(m_hs), 32'd0);
      if (p == 18) check("med restart hsync col18", 32'(m_hs), 32'd1);
    end
    rst_med = 1'b1;

    // Tiny raster, SCALE_SHIFT 0: 84 clocks per frame, 256 frames.
    rst_sml = 1'b0;
    pe_err = 0; de_err = 0; sync_err = 0; hp_err = 0;
    for (int p = 0; p <= 21504; p++) begin
      @(negedge clk);
      col    = p % 12;
      line   = (p / 12) % 7;
      exp_de = (col < 8) && (line < 4);
      if (s_pe != s_de) pe_err++;
      if (s_de != exp_de) de_err++;
      if (s_hp != (exp_de ? 8'(col) : 8'd0)) hp_err++;
      if ((s_hs != (col == 9 || col == 10)) || (s_vs != (line == 5))) sync_err++;
      if (p == 84)    check("sml frame 1", 32'(s_fr), 32'd1);
      if (p == 21503) check("sml frame 255", 32'(s_fr), 32'd255);
      if (p == 21504) check("sml frame wrap to 0", 32'(s_fr), 32'd0);
    end
    check("sml pix_en vs display_on errors", pe_err, 0);
    check("sml display window errors", de_err, 0);
    check("sml hpos errors", hp_err, 0);
    check("sml sync window errors", sync_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
